// File: rtl/fetch_pkg.sv
// Shared fetch-queue types: queue entry layout, control states and the NOP encoding.
// Entry pc field is FETCH_PC_W wide; fetch_queue WIDTH must not exceed it.
package fetch_pkg;

    localparam int FETCH_PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, synchronous clear and same-cycle push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC, instruction memory and decode; flushes drain stale responses.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
// Handshakes: a transfer happens in a cycle where valid and ready are both high; valid never waits on ready.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       PC,
    input  logic                   flush,
    output logic                   stall,
    output logic                   imem_req_valid,
    output logic [WIDTH-1:0]       imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    output logic                   dec_valid,
    output logic [31:0]            dec_instr,
    output logic [WIDTH-1:0]       dec_pc,
    input  logic                   dec_ready,
    output fetch_state_e           state_o,
    output logic [$clog2(DEPTH):0] drop_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_e     state_q;
    logic [CW-1:0]    drop_cnt_q;
    logic [CW-1:0]    occupancy, inflight, outstanding, drop_load;
    logic             q_empty, af_empty;
    logic             q_push, q_pop, req_fire, rsp_run, rsp_counted;
    logic             bypass_show, bypass_take;
    fetch_entry_t     q_head, q_wdata;
    logic [WIDTH-1:0] af_head;

    // Queued plus outstanding never exceeds DEPTH, so a response always finds a free slot.
    assign imem_req_valid = rst && !flush && (state_q == RUN) &&
                            (({1'b0, occupancy} + {1'b0, inflight}) < DEPTH_W);
    assign imem_req_addr  = PC;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign stall          = !req_fire;

    // Responses with nothing tracked in flight (e.g. issued before a reset) are ignored.
    assign rsp_run = imem_rsp_valid && (state_q == RUN) && !flush && !af_empty;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_show = rsp_run && q_empty;
`else
    assign bypass_show = 1'b0;
`endif
    assign bypass_take = bypass_show && dec_ready;

    assign q_push  = rsp_run && !bypass_take;
    assign q_pop   = !flush && !q_empty && dec_ready;
    assign q_wdata = '{pc: FETCH_PC_W'(af_head), instr: imem_rsp_data};

    // In RUN drop_cnt is zero and in DRAIN nothing is in the address FIFO, so the sum is the true count.
    assign outstanding = inflight + drop_cnt_q;
    assign rsp_counted = imem_rsp_valid && (outstanding != '0);
    assign drop_load   = outstanding - CW'(rsp_counted);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            drop_cnt_q <= '0;
        end else if (flush) begin
            drop_cnt_q <= drop_load;
            state_q    <= (drop_load != '0) ? DRAIN : RUN;
        end else if ((state_q == DRAIN) && imem_rsp_valid) begin
            drop_cnt_q <= drop_cnt_q - CW'(1);
            if (drop_cnt_q == CW'(1)) state_q <= RUN;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (q_push),
        .wdata_i (q_wdata),
        .pop_i   (q_pop),
        .rdata_o (q_head),
        .count_o (occupancy),
        .empty_o (q_empty)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (req_fire),
        .wdata_i (PC),
        .pop_i   (rsp_run),
        .rdata_o (af_head),
        .count_o (inflight),
        .empty_o (af_empty)
    );

    always_comb begin
        dec_valid = !q_empty;
        dec_instr = '0;
        dec_pc    = '0;
        if (!q_empty) begin
            dec_instr = q_head.instr;
            dec_pc    = q_head.pc[WIDTH-1:0];
        end
        if (bypass_show) begin
            dec_valid = 1'b1;
            dec_instr = imem_rsp_data;
            dec_pc    = af_head;
        end
    end

    assign state_o    = state_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC and in-order memory model, scoreboard of expected decode entries.
// Define FETCH_QUEUE_BYPASS_EN here as for the RTL to check the bypass timing.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  pc = '0;
    logic              flush = 1'b0;
    logic              stall;
    logic              imem_req_valid;
    logic [WIDTH-1:0]  imem_req_addr;
    logic              imem_req_ready = 1'b0;
    logic              imem_rsp_valid = 1'b0;
    logic [31:0]       imem_rsp_data = '0;
    logic              dec_valid;
    logic [31:0]       dec_instr;
    logic [WIDTH-1:0]  dec_pc;
    logic              dec_ready = 1'b0;
    fetch_state_e      state_o;
    logic [2:0]        drop_cnt_o;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (pc),
        .flush          (flush),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .state_o        (state_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Scoreboard and memory model state
    logic [63:0] exp_q[$];
    int          pend_due[$];
    logic [31:0] pend_data[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        s_req_valid, s_acc, s_dec_valid, s_stall, s_cons;
    logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;
    logic [2:0]  s_drop;
    logic        s_drain;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hDEADBEEF ^ (a * 32'h9E3779B9);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        imem_req_ready = 1'b0;
        dec_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        pc = '0;
        exp_q.delete();
        pend_due.delete();
        pend_data.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: entered at a falling edge with inputs set by the caller.
    task automatic tick();
        logic [63:0] e;
        imem_rsp_valid = (pend_due.size() != 0) && (pend_due[0] <= cyc);
        imem_rsp_data  = imem_rsp_valid ? pend_data[0] : 32'h0;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_acc       = imem_req_valid && imem_req_ready;
        s_dec_valid = dec_valid;
        s_dec_pc    = dec_pc;
        s_dec_instr = dec_instr;
        s_stall     = stall;
        s_drop      = drop_cnt_o;
        s_drain     = (state_o == DRAIN);
        s_cons      = dec_valid && dec_ready && !flush;
        if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(pc));
        if (flush) check("flush_noreq", 64'(imem_req_valid), 64'd0);
        check("stall", 64'(stall), 64'(!s_acc));
        if (s_cons) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("dec_entry", {dec_pc, dec_instr}, e);
            end
        end
        @(posedge clk);
        #1;
        if (imem_rsp_valid) begin
            void'(pend_due.pop_front());
            void'(pend_data.pop_front());
        end
        if (flush) exp_q.delete();
        if (s_acc) begin
            pend_due.push_back(cyc + lat);
            pend_data.push_back(memf(pc));
            exp_q.push_back({pc, memf(pc)});
            if (!flush) pc = pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int          accepts;
        bit          found;
        logic [31:0] first_pc;
        logic [31:0] instr_n, instr_n1;

        // Reset values while rst is low
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd1);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_state", 64'(state_o == DRAIN), 64'd0);
        do_reset();

        // Streaming: one entry per cycle after the fill latency
        lat = 1;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stream_stall", 64'(s_stall), 64'd0);
            check("stream_valid", 64'(s_dec_valid), 64'(i >= 2 - BYP));
            if (i >= 2 - BYP) check("stream_pc", 64'(s_dec_pc), 64'(4 * (i - (2 - BYP))));
        end

        // Decode blocked: exactly DEPTH requests, then stall; drain in order
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_acc) accepts++;
        end
        check("full_accepts", 64'(accepts), 64'(DEPTH));
        check("full_stall", 64'(s_stall), 64'd1);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_cons", 64'(s_cons), 64'd1);
            check("full_order", 64'(s_dec_pc), 64'(4 * i));
        end

        // Flush with two requests in flight, latency 3
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        pc = 32'h100;
        tick();
        flush = 1'b0;
        tick();
        check("fl_state", 64'(s_drain), 64'd1);
        check("fl_drop", 64'(s_drop), 64'd2);
        check("fl_noreq0", 64'(s_req_valid), 64'd0);
        tick();
        check("fl_noreq1", 64'(s_req_valid), 64'd0);
        found = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (s_cons) begin
                found = 1'b1;
                first_pc = s_dec_pc;
            end
        end
        check("fl_found", 64'(found), 64'd1);
        check("fl_first_pc", 64'(first_pc), 64'h100);

        // Flush coinciding with a response and dec_ready
        do_reset();
        lat = 2;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        pc = 32'h200;
        tick();
        flush = 1'b0;
        tick();
        check("flr_drop", 64'(s_drop), 64'd1);
        check("flr_state", 64'(s_drain), 64'd1);
        check("flr_dec_valid", 64'(s_dec_valid), 64'd0);
        found = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (s_cons) begin
                found = 1'b1;
                first_pc = s_dec_pc;
            end
        end
        check("flr_found", 64'(found), 64'd1);
        check("flr_first_pc", 64'(first_pc), 64'h200);

        // Response-to-decode latency on an empty queue
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        tick();
        tick();
        check("lat_valid_n", 64'(s_dec_valid), 64'(BYP));
        instr_n = s_dec_instr;
        tick();
        instr_n1 = s_dec_instr;
        check("lat_instr", 64'((BYP != 0) ? instr_n : instr_n1), 64'hDEADBEEF);

        // Asynchronous reset with a full queue
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("ar_full_valid", 64'(s_dec_valid), 64'd1);
        check("ar_full_stall", 64'(s_stall), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_dec_valid", 64'(dec_valid), 64'd0);
        check("ar_stall", 64'(stall), 64'd1);
        exp_q.delete();
        pend_due.delete();
        pend_data.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ar_req_valid", 64'(s_req_valid), 64'd1);
        check("ar_req_addr", 64'(s_req_addr), 64'h10);

        // Random traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1;
                pc = 32'($urandom_range(0, 1023)) << 2;
            end
            tick();
            flush = 1'b0;
        end

        imem_req_ready = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pend_due.size() != 0); i++) tick();
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
